burst_req_scheduler: RTL and testbench

Block-B-side controller for the clka→clkb synchronising bridge. It shares the bridge between NUM_REQ requesters in the clkb domain, one burst at a time. A round-robin arbiter grants one requester, the block issues a single-cycle data_req_clkb pulse to the bridge, and the returned data_valid_clkb/dout_clkb bytes are steered to the granted requester until BURST_LEN bytes arrive or a timeout fires. A guard gap between bursts lets the clka-side request extension expire and the FIFO drain before the next request.

---
 rtl/burst_req_sched_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/burst_req_scheduler.sv | 142 ++++++++++++++
 tb/tb_burst_req_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_req_sched_pkg.sv
`default_nettype none
// =============================================================================
// burst_req_sched_pkg - shared types and defaults for burst_req_scheduler
// Revision: 1.0
// =============================================================================
package burst_req_sched_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_BURST_LEN  = 16;
  localparam int DEF_TIMEOUT    = 64;
  localparam int DEF_GAP_CYCLES = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    RECV = 3'd3,
    GAP  = 3'd4
  } state_t;

  function automatic int RX_ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// =============================================================================
// rr_arbiter - combinational round-robin pick: first request at/after ptr
// Revision: 1.0
// =============================================================================
module rr_arbiter
  import burst_req_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [RX_ID_W(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]          grant,
  output logic [RX_ID_W(NUM_REQ)-1:0] idx,
  output logic                        found
);

  localparam int IW = RX_ID_W(NUM_REQ);

  always_comb begin
    logic [IW-1:0] cand;
    cand  = '0;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/burst_req_scheduler.sv
`default_nettype none
// =============================================================================
// burst_req_scheduler - shares the clka->clkb bridge among clkb requesters
// Revision: 1.0
// =============================================================================
module burst_req_scheduler
  import burst_req_sched_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                        clkb,
  input  logic                        reset_clkb,
  input  logic [NUM_REQ-1:0]          req_in,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        data_req_clkb,
  input  logic                        data_valid_clkb,
  input  logic [7:0]                  dout_clkb,
  output logic                        rx_valid,
  output logic [7:0]                  rx_data,
  output logic                        rx_last,
  output logic [RX_ID_W(NUM_REQ)-1:0] rx_id,
  output logic [NUM_REQ-1:0]          done,
  output logic                        err_timeout,
  output logic                        busy
);

  localparam int IW  = RX_ID_W(NUM_REQ);
  localparam int BCW = $clog2(BURST_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT);
  localparam int GCW = $clog2(GAP_CYCLES + 1);

  state_t           state, state_nxt;
  logic [IW-1:0]    ptr, ptr_nxt;
  logic [BCW-1:0]   byte_cnt;
  logic [TCW-1:0]   tcnt;
  logic [GCW-1:0]   gap_cnt;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_found;
  logic             last_byte, timed_out, gap_end;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_in),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .found (arb_found)
  );

  // Abort fires on the edge where the idle count would reach TIMEOUT-1.
  assign last_byte = data_valid_clkb && (byte_cnt + 1'b1 == BCW'(BURST_LEN));
  assign timed_out = !data_valid_clkb && (tcnt == TCW'(TIMEOUT - 2));
  assign gap_end   = (gap_cnt == GCW'(GAP_CYCLES - 1));
  assign ptr_nxt   = (rx_id == IW'(NUM_REQ - 1)) ? '0 : rx_id + 1'b1;

  always_ff @(posedge clkb or posedge reset_clkb) begin
    if (reset_clkb) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (arb_found) state_nxt = REQ;
      REQ:  state_nxt = WAIT;
      WAIT, RECV: begin
        if (data_valid_clkb)  state_nxt = last_byte ? GAP : RECV;
        else if (timed_out)   state_nxt = GAP;
      end
      GAP:  if (gap_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_req_clkb = (state == REQ);
    busy          = (state != IDLE);
  end

  always_ff @(posedge clkb or posedge reset_clkb) begin
    if (reset_clkb) begin
      grant       <= '0;
      rx_id       <= '0;
      ptr         <= '0;
      byte_cnt    <= '0;
      tcnt        <= '0;
      gap_cnt     <= '0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      rx_last     <= 1'b0;
      done        <= '0;
      err_timeout <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      rx_last     <= 1'b0;
      done        <= '0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant <= arb_grant;
            rx_id <= arb_idx;
          end
        end
        REQ: begin
          tcnt     <= '0;
          byte_cnt <= '0;
        end
        WAIT, RECV: begin
          if (data_valid_clkb) begin
            rx_valid <= 1'b1;
            rx_data  <= dout_clkb;
            byte_cnt <= byte_cnt + 1'b1;
            tcnt     <= '0;
            if (last_byte) begin
              rx_last <= 1'b1;
              done    <= grant;
              grant   <= '0;
              ptr     <= ptr_nxt;
              gap_cnt <= '0;
            end
          end else if (timed_out) begin
            err_timeout <= 1'b1;
            done        <= grant;
            grant       <= '0;
            ptr         <= ptr_nxt;
            gap_cnt     <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        GAP: gap_cnt <= gap_end ? '0 : gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_burst_req_scheduler.sv
`default_nettype none
// tb_burst_req_scheduler - randomized bursts, bridge model and scoreboard
// checking grants, forwarded bytes, done/timeout timing and guard gaps.
module tb_burst_req_scheduler;

  localparam int NUM_REQ    = 4;
  localparam int BURST_LEN  = 16;
  localparam int TIMEOUT    = 64;
  localparam int GAP_CYCLES = 16;

  logic       clkb = 1'b0;
  logic       reset_clkb = 1'b1;
  logic [3:0] req_in = '0;
  logic [3:0] grant;
  logic       data_req_clkb;
  logic       data_valid_clkb = 1'b0;
  logic [7:0] dout_clkb = '0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_last;
  logic [1:0] rx_id;
  logic [3:0] done;
  logic       err_timeout;
  logic       busy;

  burst_req_scheduler #(
    .NUM_REQ(NUM_REQ), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clkb(clkb), .reset_clkb(reset_clkb), .req_in(req_in), .grant(grant),
    .data_req_clkb(data_req_clkb), .data_valid_clkb(data_valid_clkb), .dout_clkb(dout_clkb),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last), .rx_id(rx_id),
    .done(done), .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clkb = ~clkb;

  typedef struct { int id; int data; bit last; } rx_t;
  typedef struct { int id; bit err; int nbytes; } done_t;

  rx_t   exp_rx[$];
  done_t exp_done[$];
  int    exp_grant[$];

  int checks = 0;
  int failures = 0;
  int model_ptr = 0;
  int cyc = 0;
  int req_cyc = 0, last_rx_cyc = 0, last_done_cyc = 0;
  bit gap_ref = 0;
  bit prev_req = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arbiter: first requester at or after the round-robin pointer.
  function automatic int arb_pick(input logic [3:0] m);
    for (int i = 0; i < NUM_REQ; i++)
      if (m[(model_ptr + i) % NUM_REQ]) return (model_ptr + i) % NUM_REQ;
    return -1;
  endfunction

  initial forever begin
    @(posedge clkb);
    cyc++;
  end

  // Monitor / scoreboard
  initial forever begin
    rx_t   e;
    done_t d;
    int    gid;
    @(negedge clkb);
    if (reset_clkb) begin
      prev_req = 0;
    end else begin
      if (data_req_clkb) begin
        check(!prev_req, "data_req_single_cycle", 1, 0);
        if (exp_grant.size() == 0) begin
          check(0, "unexpected_data_req", 1, 0);
        end else begin
          gid = exp_grant.pop_front();
          check(grant == 4'(1 << gid), "grant_onehot", int'(grant), 1 << gid);
          check(int'(rx_id) == gid, "rx_id", int'(rx_id), gid);
          check(busy, "busy_in_req", int'(busy), 1);
        end
        if (gap_ref)
          check(cyc - last_done_cyc == GAP_CYCLES + 1, "gap_spacing",
                cyc - last_done_cyc, GAP_CYCLES + 1);
        req_cyc = cyc;
      end
      prev_req = data_req_clkb;

      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          check(0, "unexpected_rx_valid", int'(rx_data), -1);
        end else begin
          e = exp_rx.pop_front();
          check(int'(rx_data) == e.data, "rx_data", int'(rx_data), e.data);
          check(rx_last == e.last, "rx_last", int'(rx_last), int'(e.last));
          check(int'(rx_id) == e.id, "rx_id_on_byte", int'(rx_id), e.id);
        end
        last_rx_cyc = cyc;
      end else begin
        check(!rx_last, "rx_last_without_valid", int'(rx_last), 0);
      end

      if (done != 0 || err_timeout) begin
        if (exp_done.size() == 0) begin
          check(0, "unexpected_done", int'(done), 0);
        end else begin
          d = exp_done.pop_front();
          check(done == 4'(1 << d.id), "done_bit", int'(done), 1 << d.id);
          check(err_timeout == d.err, "err_timeout", int'(err_timeout), int'(d.err));
          check(exp_rx.size() == 0, "bytes_delivered_before_done", exp_rx.size(), 0);
          check(grant == 0, "grant_dropped_in_gap", int'(grant), 0);
          if (d.err && d.nbytes == 0)
            check(cyc - req_cyc == TIMEOUT, "first_byte_timeout_latency", cyc - req_cyc, TIMEOUT);
          else if (d.err)
            check(cyc - last_rx_cyc == TIMEOUT - 1, "stall_timeout_latency",
                  cyc - last_rx_cyc, TIMEOUT - 1);
          else
            check(cyc == last_rx_cyc && rx_last, "done_with_last_byte", cyc - last_rx_cyc, 0);
        end
        last_done_cyc = cyc;
        gap_ref = 1;
      end
    end
  end

  // One burst: request, bridge response, optional strays/withdrawal/reset.
  task automatic run_burst(input logic [3:0] mask, input int nbytes, input bit b2b,
                           input bit withdraw, input bit strays, input int rst_after);
    int  id;
    bit  seen;
    int  k;
    int  idle;
    req_in = mask;
    id = arb_pick(mask);
    exp_grant.push_back(id);
    seen = 0;
    for (int w = 0; w < 100 && !seen; w++) begin
      @(negedge clkb);
      if (data_req_clkb) seen = 1;
      else begin
        data_valid_clkb = strays && ($urandom_range(0, 2) == 0);
        dout_clkb = 8'($urandom);
      end
    end
    if (!seen) begin
      check(0, "data_req_wait", 0, 1);
      data_valid_clkb = 1'b0;
      return;
    end
    exp_done.push_back('{id, (nbytes < BURST_LEN), nbytes});
    model_ptr = (id + 1) % NUM_REQ;
    // A byte sampled during the REQ cycle is stray.
    data_valid_clkb = strays && ($urandom_range(0, 1) == 1);
    dout_clkb = 8'($urandom);
    if (withdraw) req_in = '0;

    for (int b = 0; b < nbytes; b++) begin
      idle = b2b ? 0 : $urandom_range(0, 3);
      repeat (idle) begin
        @(negedge clkb);
        data_valid_clkb = 1'b0;
      end
      @(negedge clkb);
      data_valid_clkb = 1'b1;
      dout_clkb = b2b ? 8'(b) : 8'($urandom);
      exp_rx.push_back('{id, int'(dout_clkb), (b == BURST_LEN - 1)});
      if (rst_after != 0 && b + 1 == rst_after) break;
    end
    @(negedge clkb);
    data_valid_clkb = 1'b0;

    if (rst_after != 0) begin
      @(negedge clkb);
      #2 reset_clkb = 1'b1;
      #1;
      check(grant == 0 && rx_id == 0 && done == 0, "reset_grant_id_done",
            int'({grant, rx_id, done}), 0);
      check(!rx_valid && rx_data == 0 && !rx_last, "reset_rx_outputs",
            int'({rx_valid, rx_data, rx_last}), 0);
      check(!data_req_clkb && !err_timeout && !busy, "reset_ctrl_outputs",
            int'({data_req_clkb, err_timeout, busy}), 0);
      exp_grant.delete();
      exp_done.delete();
      exp_rx.delete();
      model_ptr = 0;
      gap_ref = 0;
      repeat (3) begin
        @(negedge clkb);
        data_valid_clkb = 1'b1;
        dout_clkb = 8'($urandom);
      end
      @(negedge clkb);
      data_valid_clkb = 1'b0;
      reset_clkb = 1'b0;
      return;
    end

    k = 0;
    while (done == 0 && k < TIMEOUT + 40) begin
      @(negedge clkb);
      k++;
    end
    if (done == 0) check(0, "done_wait", 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clkb);
    check(grant == 0 && !busy && !data_req_clkb && done == 0, "reset_state",
          int'({grant, busy, data_req_clkb, done}), 0);
    check(!rx_valid && !err_timeout && rx_id == 0, "reset_state_rx",
          int'({rx_valid, err_timeout, rx_id}), 0);
    reset_clkb = 1'b0;
    @(negedge clkb);

    repeat (5) run_burst(4'b1111, BURST_LEN, 1'b0, 1'b0, 1'b0, 0);
    run_burst(4'b0100, BURST_LEN, 1'b1, 1'b0, 1'b0, 0);
    run_burst(4'b0011, 0, 1'b0, 1'b0, 1'b0, 0);
    run_burst(4'b1001, 5, 1'b0, 1'b0, 1'b0, 0);
    run_burst(4'b0110, BURST_LEN, 1'b0, 1'b1, 1'b1, 0);

    for (int n = 0; n < 25; n++) begin
      logic [3:0] m;
      int nb;
      m  = 4'($urandom_range(1, 15));
      nb = ($urandom_range(0, 9) < 7) ? BURST_LEN : $urandom_range(0, BURST_LEN - 1);
      run_burst(m, nb, ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 0);
    end

    run_burst(4'b0010, BURST_LEN, 1'b0, 1'b0, 1'b0, 7);
    run_burst(4'b1000, BURST_LEN, 1'b1, 1'b0, 1'b0, 0);
    req_in = '0;

    repeat (40) @(negedge clkb);
    check(exp_rx.size() == 0 && exp_done.size() == 0 && exp_grant.size() == 0,
          "scoreboard_drained", exp_rx.size() + exp_done.size() + exp_grant.size(), 0);
    check(!busy, "idle_at_end", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
